phase_sequencer: RTL

Parametrised top-level phase sequencer. It steps a transaction through NUM_PHASES ordered phases (for example read, write, finish), starting from an idle state. A phase advances either on an external strobe (manual mode) or after a programmable dwell count (auto mode). The block adds start/abort control, looping, completion pulses and a pass counter, and drives one-hot phase enables to the datapath blocks it sequences.

---
 rtl/phase_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: steps a transaction from IDLE through NUM_PHASES ordered
// phases. Phases advance on an external strobe (manual mode) or when a
// per-phase dwell count expires (auto mode). Supports start/abort control,
// looping back to phase 1, done/aborted pulses and a saturating pass counter.
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  localparam int PH_W      = $clog2(NUM_PHASES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  strobe,
  input  logic                  abort,
  input  logic                  auto_en,
  input  logic                  loop_en,
  input  logic [CNT_W-1:0]      dwell,
  output logic [PH_W-1:0]       phase,
  output logic [NUM_PHASES:0]   phase_oh,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      loops
);

  localparam logic [PH_W-1:0] PH_IDLE  = '0;
  localparam logic [PH_W-1:0] PH_FIRST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(NUM_PHASES);

  // Dwell value as loaded into the down-counter: a dwell of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  // Pass counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_loops;
  logic             r_done;
  logic             r_aborted;

  logic [PH_W-1:0]  w_nxt_phase;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [CNT_W-1:0] w_nxt_loops;
  logic             w_nxt_done;
  logic             w_nxt_aborted;
  logic             w_adv;
  logic [NUM_PHASES:0] w_phase_oh;

  // Advance request: dwell expiry in auto mode, strobe in manual mode.
  always_comb begin
    w_adv = auto_en ? (r_cnt == '0) : strobe;
  end

  // Next-state logic; abort outranks start and advance.
  always_comb begin
    w_nxt_phase   = r_phase;
    w_nxt_cnt     = r_cnt;
    w_nxt_loops   = r_loops;
    w_nxt_done    = 1'b0;
    w_nxt_aborted = 1'b0;
    if (r_phase == PH_IDLE) begin
      // Abort in IDLE only suppresses start; nothing to abort.
      if (start && !abort) begin
        w_nxt_phase = PH_FIRST;
        w_nxt_cnt   = dwell_load(dwell);
        w_nxt_loops = '0;
      end
    end else if (abort) begin
      w_nxt_phase   = PH_IDLE;
      w_nxt_cnt     = '0;
      w_nxt_aborted = 1'b1;
    end else if (w_adv) begin
      if (r_phase == PH_LAST) begin
        w_nxt_done  = 1'b1;
        w_nxt_loops = sat_inc(r_loops);
        if (loop_en) begin
          w_nxt_phase = PH_FIRST;
          w_nxt_cnt   = dwell_load(dwell);
        end else begin
          w_nxt_phase = PH_IDLE;
          w_nxt_cnt   = '0;
        end
      end else begin
        w_nxt_phase = r_phase + PH_W'(1);
        w_nxt_cnt   = dwell_load(dwell);
      end
    end else if (auto_en) begin
      // Not advancing in auto mode implies cnt is non-zero here.
      w_nxt_cnt = r_cnt - CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= '0;
      r_loops   <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_phase   <= w_nxt_phase;
      r_cnt     <= w_nxt_cnt;
      r_loops   <= w_nxt_loops;
      r_done    <= w_nxt_done;
      r_aborted <= w_nxt_aborted;
    end
  end

  // One-hot decode of the phase index; bit 0 marks IDLE.
  always_comb begin
    w_phase_oh = '0;
    for (int i = 0; i <= NUM_PHASES; i++) begin
      w_phase_oh[i] = (r_phase == PH_W'(i));
    end
  end

  assign phase    = r_phase;
  assign phase_oh = w_phase_oh;
  assign busy     = (r_phase != PH_IDLE);
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign loops    = r_loops;

endmodule
